// File: rtl/sd_seq_pkg.sv
// sd_seq_pkg: shared definitions for the SD command sequencer.
//   - seq_state_t : sequencer FSM states
//   - SD_W_* / SD_R_* : sd_bus register indices used for writes / reads
//   - SD_ST_*     : status word bit positions
//   - sd_addr()   : builds the 18-bit register-port address from an index
package sd_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_W_ARG,
    ST_W_CMD,
    ST_W_SET,
    ST_W_TMO,
    ST_W_START,
    ST_POLL,
    ST_PCHK,
    ST_RD0,
    ST_RD1,
    ST_RD2,
    ST_RD3,
    ST_W_STOP,
    ST_CLR,
    ST_CCHK,
    ST_RESP
  } seq_state_t;

  localparam logic [10:0] SD_W_ARG   = 11'd2;
  localparam logic [10:0] SD_W_CMD   = 11'd3;
  localparam logic [10:0] SD_W_SET   = 11'd4;
  localparam logic [10:0] SD_W_START = 11'd5;
  localparam logic [10:0] SD_W_TMO   = 11'd9;

  localparam logic [10:0] SD_R_RESP0  = 11'd0;
  localparam logic [10:0] SD_R_RESP1  = 11'd1;
  localparam logic [10:0] SD_R_RESP2  = 11'd2;
  localparam logic [10:0] SD_R_RESP3  = 11'd3;
  localparam logic [10:0] SD_R_STATUS = 11'd5;

  localparam int SD_ST_CMD_FIN = 8;
  localparam int SD_ST_DAT_FIN = 10;

  // Register index to 64-bit-word byte address; bits [17:14] stay zero.
  function automatic logic [17:0] sd_addr(input logic [10:0] idx);
    return {4'b0000, idx, 3'b000};
  endfunction

endpackage

// File: rtl/sd_reg_access.sv
// sd_reg_access: performs one register-port access per request.
//   acc/we/idx/wdata : access request from the sequencer (level, held by FSM)
//   m_*              : sd_bus spisd_* register port
//   done             : write -> same cycle; read -> last cycle of the RD_LAT hold
//   rdata            : m_rddata[31:0] captured at the end of the last read cycle
module sd_reg_access
  import sd_seq_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic        msoc_clk,
  input  logic        rstn,
  input  logic        acc,
  input  logic        we,
  input  logic [10:0] idx,
  input  logic [63:0] wdata,
  output logic        m_en,
  output logic        m_we,
  output logic [7:0]  m_be,
  output logic [17:0] m_addr,
  output logic [63:0] m_wrdata,
  input  logic [63:0] m_rddata,
  output logic        done,
  output logic [31:0] rdata
);

  localparam logic [2:0] LAST = 3'(RD_LAT - 1);

  logic [2:0]  cnt;
  logic [17:0] addr_q;
  logic        rd_last;
  logic        unused_hi;

  assign unused_hi = ^m_rddata[63:32];

  assign rd_last  = acc && !we && (cnt == LAST);
  assign done     = acc && (we || (cnt == LAST));
  assign m_en     = acc;
  assign m_we     = acc && we;
  assign m_be     = (acc && we) ? 8'hFF : 8'h00;
  // Address keeps its last value between accesses.
  assign m_addr   = acc ? sd_addr(idx) : addr_q;
  assign m_wrdata = (acc && we) ? wdata : 64'd0;

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= 3'd0;
      addr_q <= 18'd0;
      rdata  <= 32'd0;
    end else begin
      if (acc) addr_q <= sd_addr(idx);
      if (acc && !we && !rd_last) cnt <= cnt + 3'd1;
      else                        cnt <= 3'd0;
      if (rd_last) rdata <= m_rddata[31:0];
    end
  end

endmodule

// File: rtl/sd_cmd_seq.sv
// sd_cmd_seq: runs one SD command on sd_bus per accepted request.
//   req_*   : command request (valid/ready)
//   resp_*  : response beat (valid/ready) with 127-bit response, status, error
//   busy    : sequencer owns the sd_bus register port
//   m_*     : sd_bus spisd_* register port
//
// state    | meaning
// IDLE     | ready for a request
// W_ARG    | write argument (idx 2)
// W_CMD    | write command index (idx 3)
// W_SET    | write {data_start,setting} (idx 4)
// W_TMO    | write timeout (idx 9)
// W_START  | write 1 to start (idx 5)
// POLL     | read status
// PCHK     | idle cycle, evaluate cmd finish / watchdog
// RD0..RD3 | read response words 0..3
// W_STOP   | write 0 to start (idx 5)
// CLR      | read status
// CCHK     | idle cycle, wait for cmd finish to drop / watchdog
// RESP     | present response until accepted
module sd_cmd_seq
  import sd_seq_pkg::*;
#(
  parameter logic [23:0] POLL_LIMIT = 24'hFFFFFF,
  parameter int          RD_LAT     = 2
) (
  input  logic         msoc_clk,
  input  logic         rstn,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [5:0]   req_cmd,
  input  logic [31:0]  req_arg,
  input  logic [2:0]   req_setting,
  input  logic [2:0]   req_data_start,
  input  logic [31:0]  req_timeout,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [127:0] resp_data,
  output logic [31:0]  resp_status,
  output logic         resp_err,
  output logic         busy,
  output logic         m_en,
  output logic         m_we,
  output logic [7:0]   m_be,
  output logic [17:0]  m_addr,
  output logic [63:0]  m_wrdata,
  input  logic [63:0]  m_rddata
);

  seq_state_t state, state_nx;

  logic             rdy_en;
  logic [5:0]       cmd_q;
  logic [31:0]      arg_q;
  logic [5:0]       set_q;
  logic [31:0]      tmo_q;
  logic [23:0]      wd_cnt;
  logic             err_q;
  logic [31:0]      status_q;
  logic [3:0][31:0] words_q;
  logic             cap_q;
  logic [1:0]       cap_sel;

  logic        acc, we, done, accept, wd_exp, cmd_fin;
  logic [10:0] idx;
  logic [63:0] wdata;
  logic [31:0] rdata;

  assign accept  = req_ready && req_valid;
  assign wd_exp  = (wd_cnt >= POLL_LIMIT);
  assign cmd_fin = rdata[SD_ST_CMD_FIN];

  assign req_ready   = (state == ST_IDLE) && rdy_en;
  assign resp_valid  = (state == ST_RESP);
  assign busy        = (state != ST_IDLE) && (state != ST_RESP);
  assign resp_err    = err_q;
  assign resp_status = status_q;
  assign resp_data   = {words_q[3], words_q[2], words_q[1], words_q[0]};

  sd_reg_access #(.RD_LAT(RD_LAT)) u_acc (
    .msoc_clk (msoc_clk),
    .rstn     (rstn),
    .acc      (acc),
    .we       (we),
    .idx      (idx),
    .wdata    (wdata),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_be     (m_be),
    .m_addr   (m_addr),
    .m_wrdata (m_wrdata),
    .m_rddata (m_rddata),
    .done     (done),
    .rdata    (rdata)
  );

  always_comb begin
    state_nx = state;
    acc      = 1'b0;
    we       = 1'b0;
    idx      = SD_R_STATUS;
    wdata    = 64'd0;
    case (state)
      ST_IDLE:    if (accept) state_nx = ST_W_ARG;
      ST_W_ARG:   begin acc = 1'b1; we = 1'b1; idx = SD_W_ARG;   wdata = {32'd0, arg_q}; state_nx = ST_W_CMD;   end
      ST_W_CMD:   begin acc = 1'b1; we = 1'b1; idx = SD_W_CMD;   wdata = {58'd0, cmd_q}; state_nx = ST_W_SET;   end
      ST_W_SET:   begin acc = 1'b1; we = 1'b1; idx = SD_W_SET;   wdata = {58'd0, set_q}; state_nx = ST_W_TMO;   end
      ST_W_TMO:   begin acc = 1'b1; we = 1'b1; idx = SD_W_TMO;   wdata = {32'd0, tmo_q}; state_nx = ST_W_START; end
      ST_W_START: begin acc = 1'b1; we = 1'b1; idx = SD_W_START; wdata = 64'd1;          state_nx = ST_POLL;    end
      ST_POLL:    begin acc = 1'b1; idx = SD_R_STATUS; if (done) state_nx = ST_PCHK; end
      // Watchdog wins over finish so POLL_LIMIT=0 always errors on the first sample.
      ST_PCHK: begin
        if (wd_exp)       state_nx = ST_W_STOP;
        else if (cmd_fin) state_nx = ST_RD0;
        else              state_nx = ST_POLL;
      end
      ST_RD0:    begin acc = 1'b1; idx = SD_R_RESP0; if (done) state_nx = ST_RD1;    end
      ST_RD1:    begin acc = 1'b1; idx = SD_R_RESP1; if (done) state_nx = ST_RD2;    end
      ST_RD2:    begin acc = 1'b1; idx = SD_R_RESP2; if (done) state_nx = ST_RD3;    end
      ST_RD3:    begin acc = 1'b1; idx = SD_R_RESP3; if (done) state_nx = ST_W_STOP; end
      ST_W_STOP: begin acc = 1'b1; we = 1'b1; idx = SD_W_START; wdata = 64'd0; state_nx = ST_CLR; end
      ST_CLR:    begin acc = 1'b1; idx = SD_R_STATUS; if (done) state_nx = ST_CCHK; end
      ST_CCHK: begin
        if (!cmd_fin || wd_exp) state_nx = ST_RESP;
        else                    state_nx = ST_CLR;
      end
      ST_RESP:   if (resp_ready) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      rdy_en   <= 1'b0;
      cmd_q    <= 6'd0;
      arg_q    <= 32'd0;
      set_q    <= 6'd0;
      tmo_q    <= 32'd0;
      wd_cnt   <= 24'd0;
      err_q    <= 1'b0;
      status_q <= 32'd0;
      words_q  <= '0;
      cap_q    <= 1'b0;
      cap_sel  <= 2'd0;
    end else begin
      state  <= state_nx;
      rdy_en <= 1'b1;

      if (accept) begin
        cmd_q    <= req_cmd;
        arg_q    <= req_arg;
        set_q    <= {req_data_start, req_setting};
        tmo_q    <= req_timeout;
        err_q    <= 1'b0;
        status_q <= 32'd0;
        words_q  <= '0;
      end

      // One watchdog for both poll phases, restarted by each start/stop write.
      if (state == ST_W_START || state == ST_W_STOP)
        wd_cnt <= 24'd0;
      else if ((state inside {ST_POLL, ST_PCHK, ST_CLR, ST_CCHK}) && (wd_cnt != 24'hFFFFFF))
        wd_cnt <= wd_cnt + 24'd1;

      if (state == ST_PCHK) begin
        status_q <= rdata;
        if (wd_exp) err_q <= 1'b1;
      end
      if (state == ST_CCHK) begin
        status_q <= rdata;
        if (cmd_fin && wd_exp) err_q <= 1'b1;
      end

      // Read data lands in rdata one cycle after done, so store it a cycle later.
      cap_q <= 1'b0;
      if (done && (state inside {ST_RD0, ST_RD1, ST_RD2, ST_RD3})) begin
        cap_q   <= 1'b1;
        cap_sel <= idx[1:0];
      end
      if (cap_q)
        words_q[cap_sel] <= (cap_sel == 2'd3) ? {1'b0, rdata[30:0]} : rdata;
    end
  end

endmodule

// File: tb/tb_sd_cmd_seq.sv
// tb_sd_cmd_seq: directed bench for sd_cmd_seq with a small sd_bus register model.
module tb_sd_cmd_seq;

  logic         msoc_clk = 1'b0;
  logic         rstn = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [5:0]   req_cmd = '0;
  logic [31:0]  req_arg = '0;
  logic [2:0]   req_setting = '0;
  logic [2:0]   req_data_start = '0;
  logic [31:0]  req_timeout = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [127:0] resp_data;
  logic [31:0]  resp_status;
  logic         resp_err;
  logic         busy;
  logic         m_en, m_we;
  logic [7:0]   m_be;
  logic [17:0]  m_addr;
  logic [63:0]  m_wrdata;
  logic [63:0]  m_rddata;

  sd_cmd_seq #(.POLL_LIMIT(24'd100), .RD_LAT(2)) dut (
    .msoc_clk       (msoc_clk),
    .rstn           (rstn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_cmd        (req_cmd),
    .req_arg        (req_arg),
    .req_setting    (req_setting),
    .req_data_start (req_data_start),
    .req_timeout    (req_timeout),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .resp_status    (resp_status),
    .resp_err       (resp_err),
    .busy           (busy),
    .m_en           (m_en),
    .m_we           (m_we),
    .m_be           (m_be),
    .m_addr         (m_addr),
    .m_wrdata       (m_wrdata),
    .m_rddata       (m_rddata)
  );

  always #5 msoc_clk = ~msoc_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // sd_bus model: registered read mux, start/stop tracking, access log.
  logic [63:0] rd_q = '0;
  logic [31:0] words[4];
  int          poll_n = 0, clr_n = 0, rsp_reads = 0, bad_fmt = 0, phase = 0;
  int          fin_after = 20, clr_hold = 0;
  int          wr_idx[$];
  logic [63:0] wr_dat[$];

  assign m_rddata = rd_q;

  initial begin
    logic        prev_rd;
    logic [10:0] prev_ix, ix;
    logic [31:0] st;
    logic        new_rd;
    prev_rd = 1'b0;
    prev_ix = '0;
    forever begin
      @(posedge msoc_clk);
      ix = m_addr[13:3];
      if (m_en) begin
        if (m_addr[17:14] != 4'd0 || m_addr[2:0] != 3'd0) bad_fmt++;
        if (m_we) begin
          if (m_be != 8'hFF) bad_fmt++;
          wr_idx.push_back(int'(ix));
          wr_dat.push_back(m_wrdata);
          if (ix == 11'd5) begin
            if (m_wrdata[0]) begin phase = 1; poll_n = 0; end
            else             begin phase = 2; clr_n = 0;  end
          end
        end else begin
          if (m_be != 8'h00) bad_fmt++;
          new_rd = !(prev_rd && prev_ix == ix);
          if (new_rd && ix == 11'd5) begin
            if (phase == 1)      poll_n++;
            else if (phase == 2) clr_n++;
          end
          if (new_rd && ix < 11'd4) rsp_reads++;
          st = 32'h0000_0400;
          if (phase == 1 && poll_n > fin_after) st[8] = 1'b1;
          if (phase == 2 && clr_n <= clr_hold)  st[8] = 1'b1;
          if (ix < 11'd4)       rd_q <= {32'hDEAD_0000, words[ix[1:0]]};
          else if (ix == 11'd5) rd_q <= {32'hDEAD_0000, st};
          else                  rd_q <= 64'd0;
        end
      end
      prev_rd = m_en && !m_we;
      prev_ix = ix;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge msoc_clk);
    #1;
  endtask

  task automatic clear_log();
    wr_idx.delete();
    wr_dat.delete();
    rsp_reads = 0;
  endtask

  // Returns in the first cycle after acceptance (the W_ARG cycle).
  task automatic send_req(input logic [5:0] cmd, input logic [31:0] arg,
                          input logic [2:0] set, input logic [2:0] ds, input logic [31:0] tmo);
    req_cmd = cmd; req_arg = arg; req_setting = set; req_data_start = ds; req_timeout = tmo;
    req_valid = 1'b1;
    for (int i = 0; i < 300 && !req_ready; i++) tick();
    chk("req_accept", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int t);
    t = 0;
    while (!resp_valid && t < 400) begin
      tick();
      t++;
    end
    chk("resp_seen", resp_valid, 1'b1);
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    int t;
    logic [127:0] snap, exp_rd;
    logic stable;
    int          exp_idx[6];
    logic [63:0] exp_dat[6];

    words[0] = 32'h11111111; words[1] = 32'h22222222;
    words[2] = 32'h33333333; words[3] = 32'h7FFFFFFF;

    // reset
    repeat (3) tick();
    chk("rst_out", {req_ready, busy, m_en, m_we, resp_valid, resp_err, m_be, m_addr, m_wrdata}, '0);
    chk("rst_resp", {resp_data, resp_status}, '0);
    rstn = 1'b1;
    #1;
    chk("rdy_first", req_ready, 1'b0);
    tick();
    chk("rdy_after", req_ready, 1'b1);

    // basic command
    fin_after = 20; clr_hold = 0;
    clear_log();
    send_req(6'd8, 32'h1AA, 3'b001, 3'b000, 32'd5000);
    chk("busy_run", {busy, req_ready}, 2'b10);
    wait_resp(t);
    exp_idx = '{2, 3, 4, 9, 5, 5};
    exp_dat = '{64'h1AA, 64'd8, 64'd1, 64'd5000, 64'd1, 64'd0};
    chk("basic_nwr", wr_idx.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < wr_idx.size()) begin
        chk($sformatf("basic_idx%0d", i), wr_idx[i], exp_idx[i]);
        chk($sformatf("basic_dat%0d", i), wr_dat[i], exp_dat[i]);
      end
    end
    chk("basic_data", resp_data, {32'h7FFFFFFF, 32'h33333333, 32'h22222222, 32'h11111111});
    chk("basic_err", resp_err, 1'b0);
    chk("basic_status", resp_status, 32'h400);
    chk("basic_polls", poll_n, 21);
    chk("basic_rsp_reads", rsp_reads, 4);
    chk("basic_resp_flags", {busy, req_ready}, 2'b00);
    ack();

    // backpressure with a queued request
    fin_after = 2;
    clear_log();
    send_req(6'd2, 32'h0, 3'b000, 3'b000, 32'd0);
    wait_resp(t);
    snap = resp_data;
    chk("bp_data", snap, {32'h7FFFFFFF, 32'h33333333, 32'h22222222, 32'h11111111});
    req_cmd = 6'd9; req_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!resp_valid || resp_data !== snap || req_ready || m_en) stable = 1'b0;
    end
    chk("bp_stable", stable, 1'b1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("bp_after_hs", {resp_valid, req_ready, m_en}, 3'b010);
    tick();
    req_valid = 1'b0;
    chk("bp_next_start", {m_en, m_we, m_addr[13:3]}, {2'b11, 11'd2});
    wait_resp(t);
    ack();

    // clear wait: cmd finish stays high for 10 polls after stop
    fin_after = 0; clr_hold = 10;
    clear_log();
    send_req(6'd12, 32'h5, 3'b010, 3'b001, 32'd10);
    wait_resp(t);
    chk("clr_polls", clr_n, 11);
    chk("clr_err", resp_err, 1'b0);
    chk("clr_status", resp_status, 32'h400);
    ack();
    clr_hold = 0;

    // watchdog: cmd finish never sets
    fin_after = 1000000;
    clear_log();
    send_req(6'd55, 32'hABCD, 3'b001, 3'b000, 32'd1);
    t = 0;
    while (!resp_err && t < 200) begin
      tick();
      t++;
    end
    chk("wd_seen", resp_err, 1'b1);
    chk("wd_not_early", t >= 100, 1'b1);
    chk("wd_in_bound", t <= 115, 1'b1);
    wait_resp(t);
    chk("wd_err", resp_err, 1'b1);
    chk("wd_rsp_reads", rsp_reads, 0);
    chk("wd_nwr", wr_idx.size(), 6);
    if (wr_idx.size() > 0) chk("wd_stop", {wr_idx[$], wr_dat[$]}, {32'd5, 64'd0});
    chk("wd_data", resp_data, '0);
    ack();

    // reset in the middle of polling
    fin_after = 30;
    clear_log();
    send_req(6'd20, 32'h1, 3'b001, 3'b000, 32'd1);
    t = 0;
    while (!(m_en && !m_we && m_addr[13:3] == 11'd5) && t < 50) begin
      tick();
      t++;
    end
    chk("rm_in_poll", {m_en, m_we, m_addr[13:3]}, {2'b10, 11'd5});
    rstn = 1'b0;
    #1;
    chk("rm_async", {busy, m_en, resp_valid, req_ready, resp_err}, 5'b0);
    tick();
    rstn = 1'b1;
    fin_after = 3;
    clear_log();
    send_req(6'd33, 32'h77, 3'b001, 3'b000, 32'd9);
    wait_resp(t);
    chk("rm_nwr", wr_idx.size(), 6);
    if (wr_idx.size() > 1) begin
      chk("rm_first", wr_idx[0], 2);
      chk("rm_cmd", wr_dat[1], 64'd33);
    end
    chk("rm_data", resp_data, {32'h7FFFFFFF, 32'h33333333, 32'h22222222, 32'h11111111});
    ack();

    // back-to-back, with response word 3 bit 31 set on the bus
    fin_after = 0;
    words[3] = 32'hFFFFFFFF;
    clear_log();
    send_req(6'd17, 32'hCAFE0001, 3'b101, 3'b010, 32'd7);
    req_cmd = 6'd18; req_arg = 32'hCAFE0002; req_valid = 1'b1;
    wait_resp(t);
    exp_rd = {32'h7FFFFFFF, 32'h33333333, 32'h22222222, 32'h11111111};
    chk("b2b_mask", resp_data, exp_rd);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("b2b_gap", {m_en, req_ready}, 2'b01);
    tick();
    req_valid = 1'b0;
    chk("b2b_start", {m_en, m_we, m_addr[13:3]}, {2'b11, 11'd2});
    wait_resp(t);
    chk("b2b_latency", t, 20);
    chk("b2b_nwr", wr_idx.size(), 12);
    if (wr_idx.size() >= 12) begin
      chk("b2b_set", wr_dat[2], 64'h15);
      chk("b2b_cmd1", wr_dat[1], 64'd17);
      chk("b2b_cmd2", wr_dat[7], 64'd18);
      chk("b2b_arg2", wr_dat[6], 64'hCAFE0002);
    end
    ack();

    chk("port_format", bad_fmt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
